// File: rtl/br32_pkg.sv
// Shared widths and operand-source encoding for the register-read stage.
package br32_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RW    = $clog2(NREGS);

    // Where a forwarded operand came from, highest priority first.
    typedef enum logic [1:0] {
        FWD_EX  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_RF  = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/stage_rr_if.sv
// Decode -> register-read handshake bundle.
interface stage_rr_if;
    import br32_pkg::*;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_use_cr;
    logic [RW-1:0]   id_rd;
    logic            id_w_rd;
    logic            id_w_cr;
    logic            id_is_load;

    // Decode side presents the instruction and watches ready.
    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_use_cr, id_rd, id_w_rd, id_w_cr, id_is_load,
        input  id_ready
    );

    // Register-read side consumes the instruction and drives ready.
    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_use_cr, id_rd, id_w_rd, id_w_cr, id_is_load,
        output id_ready
    );

endinterface

// File: rtl/stage_rr_fwd_mux.sv
// One source-operand forwarding mux: EX > MEM > WB > register file.
module rr_fwd_mux
    import br32_pkg::*;
(
    input  logic [RW-1:0]   idx,
    input  logic            ex_w,
    input  logic [RW-1:0]   ex_rd,
    input  logic [XLEN-1:0] ex_res,
    input  logic            mem_w,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_res,
    input  logic            wb_w,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_res,
    input  logic [XLEN-1:0] rf_val,
    output logic [XLEN-1:0] val,
    output fwd_src_e        src
);

    // Pick the youngest in-flight producer of idx; r0 is an ordinary register.
    always_comb begin
        val = rf_val;
        src = FWD_RF;
        if (ex_w && (ex_rd == idx)) begin
            val = ex_res;
            src = FWD_EX;
        end else if (mem_w && (mem_rd == idx)) begin
            val = mem_res;
            src = FWD_MEM;
        end else if (wb_w && (wb_rd == idx)) begin
            val = wb_res;
            src = FWD_WB;
        end
    end

endmodule

// File: rtl/stage_rr.sv
// Register-read stage: operand read + forwarding, load-use stall, EX pipeline register.
module stage_rr
    import br32_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    stage_rr_if.slave                  id,
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [1:0]                 cmp_reg,
    input  logic                       ex_w_rd,
    input  logic [RW-1:0]              ex_rd,
    input  logic [XLEN-1:0]            ex_res,
    input  logic                       ex_is_load,
    input  logic                       ex_w_cr,
    input  logic [1:0]                 ex_cmp_res,
    input  logic                       mem_w_rd,
    input  logic [RW-1:0]              mem_rd,
    input  logic [XLEN-1:0]            mem_res,
    input  logic                       mem_w_cr,
    input  logic [1:0]                 mem_cmp_res,
    input  logic                       wb_w_rd,
    input  logic [RW-1:0]              wb_rd,
    input  logic [XLEN-1:0]            wb_res,
    output logic [XLEN-1:0]            rr_pc,
    output logic [XLEN-1:0]            rr_op1,
    output logic [XLEN-1:0]            rr_op2,
    output logic [RW-1:0]              rr_rd,
    output logic                       rr_w_rd,
    output logic                       rr_w_cr,
    output logic                       rr_is_load,
    output logic [1:0]                 rr_cr,
    output logic                       rr_bubble,
    output logic [31:0]                stall_cnt
);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---- stage p0: combinational read, forward and hazard detect ----
    logic            ex_fwd_ok;
    logic [XLEN-1:0] op1_p0;
    logic [XLEN-1:0] op2_p0;
    logic [1:0]      cr_p0;
    fwd_src_e        op1_src_p0;
    fwd_src_e        op2_src_p0;
    logic            haz_p0;

    // A load in EX has no data yet; it can only be forwarded once it reaches MEM.
    assign ex_fwd_ok = ex_w_rd && !ex_is_load;

    rr_fwd_mux u_fwd_rs1 (
        .idx     (id.id_rs1),
        .ex_w    (ex_fwd_ok),
        .ex_rd   (ex_rd),
        .ex_res  (ex_res),
        .mem_w   (mem_w_rd),
        .mem_rd  (mem_rd),
        .mem_res (mem_res),
        .wb_w    (wb_w_rd),
        .wb_rd   (wb_rd),
        .wb_res  (wb_res),
        .rf_val  (regs[id.id_rs1]),
        .val     (op1_p0),
        .src     (op1_src_p0)
    );

    rr_fwd_mux u_fwd_rs2 (
        .idx     (id.id_rs2),
        .ex_w    (ex_fwd_ok),
        .ex_rd   (ex_rd),
        .ex_res  (ex_res),
        .mem_w   (mem_w_rd),
        .mem_rd  (mem_rd),
        .mem_res (mem_res),
        .wb_w    (wb_w_rd),
        .wb_rd   (wb_rd),
        .wb_res  (wb_res),
        .rf_val  (regs[id.id_rs2]),
        .val     (op2_p0),
        .src     (op2_src_p0)
    );

    // Source tags are for debug visibility only.
    logic unused_src;
    assign unused_src = ^{op1_src_p0, op2_src_p0};

    assign cr_p0 = ex_w_cr  ? ex_cmp_res  :
                   mem_w_cr ? mem_cmp_res : cmp_reg;

    assign haz_p0 = id.id_valid && ex_w_rd && ex_is_load &&
                    ((id.id_use_rs1 && (id.id_rs1 == ex_rd)) ||
                     (id.id_use_rs2 && (id.id_rs2 == ex_rd)));

    // A redirect kills the ID instruction, so a stall on it is pointless.
    assign id.id_ready = !haz_p0 || flush;

    // ---- stage p1: EX-facing pipeline register ----
    // Latch accepted instructions; flush, stall or idle all inject a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_bubble  <= 1'b1;
            rr_pc      <= '0;
            rr_op1     <= '0;
            rr_op2     <= '0;
            rr_rd      <= '0;
            rr_w_rd    <= 1'b0;
            rr_w_cr    <= 1'b0;
            rr_is_load <= 1'b0;
            rr_cr      <= '0;
        end else if (flush || haz_p0) begin
            rr_bubble  <= 1'b1;
        end else if (id.id_valid) begin
            rr_bubble  <= 1'b0;
            rr_pc      <= id.id_pc;
            rr_op1     <= op1_p0;
            rr_op2     <= op2_p0;
            rr_rd      <= id.id_rd;
            rr_w_rd    <= id.id_w_rd;
            rr_w_cr    <= id.id_w_cr;
            rr_is_load <= id.id_is_load;
            rr_cr      <= cr_p0;
        end else begin
            rr_bubble  <= 1'b1;
        end
    end

    // Count cycles lost to load-use stalls; a flushed stall is not a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!flush && haz_p0) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_stage_rr.sv
// Directed bench for stage_rr.
module tb_stage_rr;
    import br32_pkg::*;

    logic                       clk;
    logic                       rst_n;
    logic                       flush;
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [1:0]                 cmp_reg;
    logic                       ex_w_rd, ex_is_load, ex_w_cr;
    logic [RW-1:0]              ex_rd;
    logic [XLEN-1:0]            ex_res;
    logic [1:0]                 ex_cmp_res;
    logic                       mem_w_rd, mem_w_cr;
    logic [RW-1:0]              mem_rd;
    logic [XLEN-1:0]            mem_res;
    logic [1:0]                 mem_cmp_res;
    logic                       wb_w_rd;
    logic [RW-1:0]              wb_rd;
    logic [XLEN-1:0]            wb_res;
    logic [XLEN-1:0]            rr_pc, rr_op1, rr_op2;
    logic [RW-1:0]              rr_rd;
    logic                       rr_w_rd, rr_w_cr, rr_is_load, rr_bubble;
    logic [1:0]                 rr_cr;
    logic [31:0]                stall_cnt;

    int total = 0;
    int bad   = 0;

    stage_rr_if idb ();

    stage_rr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .id          (idb),
        .regs        (regs),
        .cmp_reg     (cmp_reg),
        .ex_w_rd     (ex_w_rd),
        .ex_rd       (ex_rd),
        .ex_res      (ex_res),
        .ex_is_load  (ex_is_load),
        .ex_w_cr     (ex_w_cr),
        .ex_cmp_res  (ex_cmp_res),
        .mem_w_rd    (mem_w_rd),
        .mem_rd      (mem_rd),
        .mem_res     (mem_res),
        .mem_w_cr    (mem_w_cr),
        .mem_cmp_res (mem_cmp_res),
        .wb_w_rd     (wb_w_rd),
        .wb_rd       (wb_rd),
        .wb_res      (wb_res),
        .rr_pc       (rr_pc),
        .rr_op1      (rr_op1),
        .rr_op2      (rr_op2),
        .rr_rd       (rr_rd),
        .rr_w_rd     (rr_w_rd),
        .rr_w_cr     (rr_w_cr),
        .rr_is_load  (rr_is_load),
        .rr_cr       (rr_cr),
        .rr_bubble   (rr_bubble),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        ex_w_rd = 0; ex_is_load = 0; ex_w_cr = 0; ex_rd = '0; ex_res = '0; ex_cmp_res = '0;
        mem_w_rd = 0; mem_w_cr = 0; mem_rd = '0; mem_res = '0; mem_cmp_res = '0;
        wb_w_rd = 0; wb_rd = '0; wb_res = '0;
    endtask

    task automatic set_id(input logic [XLEN-1:0] pc, input logic [RW-1:0] rs1,
                          input logic [RW-1:0] rs2, input logic u1, input logic u2);
        idb.id_valid = 1; idb.id_pc = pc; idb.id_rs1 = rs1; idb.id_rs2 = rs2;
        idb.id_use_rs1 = u1; idb.id_use_rs2 = u2; idb.id_use_cr = 0;
        idb.id_rd = 5'd9; idb.id_w_rd = 1; idb.id_w_cr = 0; idb.id_is_load = 0;
    endtask

    initial begin
        rst_n = 0; flush = 0; cmp_reg = 2'b00;
        for (int i = 0; i < NREGS; i++) regs[i] = '0;
        clear_fwd();
        set_id('0, '0, '0, 0, 0);
        idb.id_valid = 0;

        // Reset state
        #12;
        chk("rst_bubble", rr_bubble, 1);
        chk("rst_op1", rr_op1, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_ready", idb.id_ready, 1);
        rst_n = 1;

        // Regfile read
        regs[5] = 32'h1234;
        set_id(32'h100, 5'd5, 5'd6, 1, 1);
        step();
        chk("rf_op1", rr_op1, 32'h1234);
        chk("rf_bubble", rr_bubble, 0);
        chk("rf_pc", rr_pc, 32'h100);
        chk("rf_rd", rr_rd, 9);
        chk("rf_w_rd", rr_w_rd, 1);

        // Forward priority on rs2
        ex_w_rd = 1; ex_rd = 3; ex_res = 32'hA;
        mem_w_rd = 1; mem_rd = 3; mem_res = 32'hB;
        wb_w_rd = 1; wb_rd = 3; wb_res = 32'hC;
        set_id(32'h104, 5'd5, 5'd3, 1, 1);
        step();
        chk("fwd_ex", rr_op2, 32'hA);
        ex_w_rd = 0;
        step();
        chk("fwd_mem", rr_op2, 32'hB);
        mem_w_rd = 0;
        step();
        chk("fwd_wb", rr_op2, 32'hC);
        // A load in EX is never a forwarding source
        ex_w_rd = 1; ex_is_load = 1; mem_w_rd = 1; idb.id_use_rs2 = 0;
        step();
        chk("fwd_exload", rr_op2, 32'hB);
        // r0 forwards like any register
        clear_fwd();
        wb_w_rd = 1; wb_rd = 0; wb_res = 32'h77;
        set_id(32'h108, 5'd0, 5'd0, 1, 1);
        step();
        chk("fwd_r0", rr_op1, 32'h77);

        // Load-use stall
        clear_fwd();
        ex_w_rd = 1; ex_is_load = 1; ex_rd = 7; ex_res = 32'h99;
        set_id(32'h200, 5'd7, 5'd1, 1, 0);
        #1;
        chk("lu_ready", idb.id_ready, 0);
        step();
        chk("lu_bubble", rr_bubble, 1);
        chk("lu_stall", stall_cnt, 1);
        chk("lu_pc_hold", rr_pc, 32'h108);
        ex_w_rd = 0; ex_is_load = 0;
        mem_w_rd = 1; mem_rd = 7; mem_res = 32'h55;
        #1;
        chk("lu_ready2", idb.id_ready, 1);
        step();
        chk("lu_op1", rr_op1, 32'h55);
        chk("lu_bubble2", rr_bubble, 0);
        chk("lu_pc", rr_pc, 32'h200);
        chk("lu_stall2", stall_cnt, 1);

        // Flush during stall
        clear_fwd();
        ex_w_rd = 1; ex_is_load = 1; ex_rd = 7;
        flush = 1;
        #1;
        chk("fl_ready", idb.id_ready, 1);
        step();
        chk("fl_bubble", rr_bubble, 1);
        chk("fl_stall", stall_cnt, 1);
        flush = 0;

        // CR forwarding
        clear_fwd();
        set_id(32'h300, 5'd1, 5'd2, 0, 0);
        idb.id_use_cr = 1; idb.id_w_cr = 1;
        cmp_reg = 2'b00; mem_w_cr = 1; mem_cmp_res = 2'b01;
        step();
        chk("cr_mem", rr_cr, 2'b01);
        chk("cr_w_cr", rr_w_cr, 1);
        ex_w_cr = 1; ex_cmp_res = 2'b10;
        step();
        chk("cr_ex", rr_cr, 2'b10);
        ex_w_cr = 0; mem_w_cr = 0; cmp_reg = 2'b11;
        step();
        chk("cr_arch", rr_cr, 2'b11);

        // Idle decode
        idb.id_valid = 0;
        step();
        chk("idle_bubble", rr_bubble, 1);

        // Reset mid-stall
        clear_fwd();
        ex_w_rd = 1; ex_is_load = 1; ex_rd = 4;
        set_id(32'h400, 5'd4, 5'd4, 1, 0);
        step();
        chk("ms_stall", stall_cnt, 2);
        #2;
        rst_n = 0;
        #1;
        chk("ms_bubble", rr_bubble, 1);
        chk("ms_stall0", stall_cnt, 0);
        chk("ms_op1", rr_op1, 0);
        chk("ms_cr", rr_cr, 0);
        #3;
        rst_n = 1;
        clear_fwd();
        step();
        chk("ms_repres", rr_pc, 32'h400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
